onehot_decoder_seq: RTL

Parametrised, registered binary-to-one-hot decoder, the next generation of the team's 3-to-8 clocked decoder. It widens the select to `SEL_W` bits and supports a non-power-of-two output count `OUT_N`. It adds a valid/ready input handshake, out-of-range error reporting, and an autonomous SCAN mode that walks the outputs with a programmable dwell. It sits between control logic and strobe or chip-select fan-out.

---
 rtl/dec_pkg.sv | 29 ++
 rtl/dec_scan_ctr.sv | 41 ++++
 rtl/onehot_decoder_seq.sv | 113 +++++++++++
 3 files changed

// File: rtl/dec_pkg.sv
// Shared types and helpers for the sequential one-hot decoder.
package dec_pkg;

   typedef enum logic [1:0] {
      MODE_IDLE   = 2'd0,
      MODE_DIRECT = 2'd1,
      MODE_SCAN   = 2'd2
   } mode_e;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_DIRECT = 2'd1,
      S_SCAN   = 2'd2
   } state_e;

   // Widest one-hot vector the helper can produce; OUT_N must not exceed it.
   localparam int unsigned ONEHOT_W = 64;

   // One-hot vector with bit idx set.
   function automatic logic [ONEHOT_W-1:0] onehot(input int unsigned idx);
      return ONEHOT_W'(1) << idx;
   endfunction

   // Scan index successor, wrapping explicitly at n-1.
   function automatic int unsigned next_idx(input int unsigned idx, input int unsigned n);
      return (idx >= n - 32'd1) ? 32'd0 : idx + 32'd1;
   endfunction

endpackage

// File: rtl/dec_scan_ctr.sv
// Dwell counter and wrapping scan index for the SCAN walk.
module dec_scan_ctr
   import dec_pkg::*;
#(
   parameter int unsigned SEL_W   = 3,
   parameter int unsigned OUT_N   = 8,
   parameter int unsigned DWELL_W = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic               clr,
   input  logic [DWELL_W-1:0] dwell,
   output logic [SEL_W-1:0]   idx,
   output logic               step
);

   logic [DWELL_W-1:0] cnt;

   // Terminal count of the current dwell; the live dwell value is compared every cycle.
   assign step = en && (cnt == dwell);

   // Counter and index advance; clr restarts the walk at output 0.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
         idx <= '0;
      end else if (clr) begin
         cnt <= '0;
         idx <= '0;
      end else if (en) begin
         if (cnt == dwell) begin
            cnt <= '0;
            idx <= SEL_W'(next_idx(32'(idx), OUT_N));
         end else begin
            cnt <= cnt + DWELL_W'(1);
         end
      end
   end

endmodule

// File: rtl/onehot_decoder_seq.sv
// Registered binary-to-one-hot decoder with valid/ready input, range error and SCAN walk.
// Optional feature macro: ONEHOT_DECODER_STICKY_ERR_EN (err survives SCAN entry).
module onehot_decoder_seq
   import dec_pkg::*;
#(
   parameter int unsigned SEL_W   = 3,
   parameter int unsigned OUT_N   = 8,
   parameter int unsigned DWELL_W = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [1:0]         mode,
   input  logic [SEL_W-1:0]   sel,
   input  logic               sel_vld,
   output logic               sel_rdy,
   input  logic [DWELL_W-1:0] dwell,
   output logic [OUT_N-1:0]   y,
   output logic               y_vld,
   output logic               err,
   output logic               busy
);

   localparam int unsigned SEL_X = SEL_W + 1;
   localparam logic [SEL_X-1:0] OUT_LIM = SEL_X'(OUT_N);

   state_e           state_q;
   state_e           next_state;
   logic             scan_entry;
   logic             scan_en;
   logic             accept;
   logic             in_range;
   logic [SEL_W-1:0] scan_idx;
   logic             scan_step;

   // Next state is the decoded mode; the reserved encoding falls to idle.
   always_comb begin
      next_state = S_IDLE;
      case (mode)
         MODE_DIRECT: next_state = S_DIRECT;
         MODE_SCAN:   next_state = S_SCAN;
         default:     next_state = S_IDLE;
      endcase
   end

   assign scan_entry = (state_q != S_SCAN) && (next_state == S_SCAN);
   assign scan_en    = (state_q == S_SCAN);
   assign accept     = sel_vld && sel_rdy;
   // An X select fails this compare and lands in the out-of-range branch.
   assign in_range   = ({1'b0, sel} < OUT_LIM);

   dec_scan_ctr #(
      .SEL_W   (SEL_W),
      .OUT_N   (OUT_N),
      .DWELL_W (DWELL_W)
   ) u_scan_ctr (
      .clk   (clk),
      .rst   (rst),
      .en    (scan_en),
      .clr   (scan_entry),
      .dwell (dwell),
      .idx   (scan_idx),
      .step  (scan_step)
   );

   // State register, handshake and output registers; the current state decides the action.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         y       <= '0;
         y_vld   <= 1'b0;
         err     <= 1'b0;
         sel_rdy <= 1'b0;
         busy    <= 1'b0;
      end else begin
         state_q <= next_state;
         sel_rdy <= (next_state == S_DIRECT);
         busy    <= (next_state == S_SCAN);
         y_vld   <= 1'b0;
         case (state_q)
            S_DIRECT: begin
               if (accept) begin
                  y_vld <= 1'b1;
                  if (in_range) begin
                     y   <= OUT_N'(onehot(32'(sel)));
                     err <= 1'b0;
                  end else begin
                     y   <= '0;
                     err <= 1'b1;
                  end
               end
            end
            S_SCAN: begin
               if (scan_step) begin
                  y     <= OUT_N'(onehot(next_idx(32'(scan_idx), OUT_N)));
                  y_vld <= 1'b1;
               end
            end
            default: begin
            end
         endcase
         if (scan_entry) begin
            y     <= OUT_N'(onehot(32'd0));
            y_vld <= 1'b1;
`ifdef ONEHOT_DECODER_STICKY_ERR_EN
            // Error stays latched until reset or an in-range direct accept.
`else
            err   <= 1'b0;
`endif
         end
      end
   end

endmodule
